pc_redirect_ctrl: RTL and testbench
===================================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter BUBBLE_CYCLES, default 1, meaning the number of stall cycles held after each redirect (range 0..7).
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_0010, meaning the exception handler PC.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have port jmp_req, input, 1, meaning the decode-stage absolute jump request.
REQ-006 SHALL have port jmp_tgt, input, 27, meaning the jump immediate field.
REQ-007 SHALL have port jmp_pc, input, 32, meaning the PC of the jump instruction.
REQ-008 SHALL have port br_req, input, 1, meaning the execute-stage taken branch.
REQ-009 SHALL have port br_tgt, input, 32, meaning the computed branch target.
REQ-010 SHALL have port exc_req, input, 1, meaning the exception request.
REQ-011 SHALL have ports jmp_ack, br_ack and exc_ack, output, 1 each, meaning a one-cycle request-accepted pulse.
REQ-012 SHALL have port redirect_valid, output, 1, meaning load redirect_pc into the PC this cycle.
REQ-013 SHALL have port redirect_pc, output, 32, meaning the new PC.
REQ-014 SHALL have ports flush_fd and flush_dx, output, 1 each, meaning squash the F/D and D/X latches.
REQ-015 SHALL have port stall_f, output, 1, meaning hold the fetch PC.

Function
REQ-016 SHALL compute the jump target as jmp_tgt sign-extended from bit 26 to 32 bits.
REQ-017 SHALL arbitrate with fixed priority exc > br > jmp, so the oldest instruction wins.
REQ-018 SHALL use FSM states IDLE, REDIRECT and BUBBLE.
REQ-019 SHALL, in IDLE with any request asserted, register the winner's target, pulse its ack in the same cycle, and move to REDIRECT.
REQ-020 SHALL, in REDIRECT, assert redirect_valid for exactly one cycle with the registered target; this is one-cycle latency from request.
REQ-021 SHALL assert flush_fd in REDIRECT for any source, and also assert flush_dx when the source is br or exc.
REQ-022 SHALL move from REDIRECT to BUBBLE when BUBBLE_CYCLES > 0, otherwise to IDLE.
REQ-023 SHALL, in BUBBLE, assert stall_f while a down-counter counts BUBBLE_CYCLES cycles, then return to IDLE.
REQ-024 SHALL ignore jmp_req and br_req outside IDLE, with no ack, because those requesters are being flushed.
REQ-025 SHALL accept exc_req in REDIRECT or BUBBLE by pre-empting: ack it, load EXC_VECTOR, re-enter REDIRECT, and reset the counter.
REQ-026 SHALL, when requests arrive simultaneously, ack only the winner; losers receive no ack.
REQ-027 SHALL never assert more than one ack in any cycle.

Reset
REQ-028 SHALL, on resetn low, immediately force state to IDLE, the counter to 0, redirect_pc to 0, and all single-bit outputs to 0, including mid-redirect.
REQ-029 SHALL not treat a request present during the first cycle after resetn rises as special; normal IDLE arbitration applies.

Configuration
REQ-030 SHALL, with JMP_LINK_EN defined, add outputs link_we (1) and link_data (32); link_we pulses in REDIRECT for jmp-sourced redirects and link_data equals jmp_pc+1 registered at acceptance.
REQ-031 SHALL, without JMP_LINK_EN, omit the link ports and logic entirely.

Structure
REQ-032 SHALL place the state enum, the source encoding (SRC_NONE/JMP/BR/EXC) and the default EXC_VECTOR constant in shared package pc_redirect_pkg.
REQ-033 SHALL implement the bubble counter as sub-module redirect_bubble_cnt (load, decrement, zero flag).

Verification
REQ-034 SHALL cover: jmp_req with jmp_tgt=27'h4000000 -> next cycle redirect_valid=1, redirect_pc=32'hFC000000, flush_fd=1, flush_dx=0.
REQ-035 SHALL cover: br_req and jmp_req in the same cycle, br_tgt=32'h100 -> br_ack=1, jmp_ack=0, redirect_pc=32'h100, flush_dx=1.
REQ-036 SHALL cover: BUBBLE_CYCLES=3, single branch -> stall_f high for exactly 3 cycles after the redirect, then IDLE.
REQ-037 SHALL cover: exc_req during BUBBLE -> exc_ack, redirect_pc=32'h10 on the next cycle, and a full bubble restarted.
REQ-038 SHALL cover: resetn low during REDIRECT -> all outputs 0 asynchronously, and IDLE after release.
REQ-039 SHALL cover: with JMP_LINK_EN, jmp at jmp_pc=32'h20 -> link_we=1 and link_data=32'h21 in the REDIRECT cycle.

Source files
------------

// File: rtl/pc_redirect_pkg.sv
// Shared types and constants for the PC redirect controller and its bubble counter.
package pc_redirect_pkg;

  typedef enum logic [1:0] {IDLE, REDIRECT, BUBBLE} state_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_JMP, SRC_BR, SRC_EXC} src_t;

  typedef logic [2:0] bcnt_t;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0010;

  function automatic logic [31:0] sext_jmp(input logic [26:0] imm);
    return {{5{imm[26]}}, imm};
  endfunction

endpackage

// File: rtl/redirect_bubble_cnt.sv
// Down-counter that times the post-redirect fetch bubble; zero marks the last bubble cycle.
module redirect_bubble_cnt
  import pc_redirect_pkg::*;
(
  input  logic  clock,
  input  logic  resetn,
  input  logic  clr,
  input  logic  load,
  input  bcnt_t load_val,
  input  logic  dec,
  output logic  zero
);

  bcnt_t cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - bcnt_t'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Arbitrates jump/branch/exception redirects and sequences flush and fetch bubble.
// Optional return-link outputs are built when JMP_LINK_EN is defined.
//
// state    | meaning
// IDLE     | waiting for a request; arbitrate exc > br > jmp
// REDIRECT | redirect_valid with registered target, flush latches
// BUBBLE   | stall_f held for BUBBLE_CYCLES cycles
module pc_redirect_ctrl
  import pc_redirect_pkg::*;
#(
  parameter int unsigned BUBBLE_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        jmp_req,
  input  logic [26:0] jmp_tgt,
  input  logic [31:0] jmp_pc,
  input  logic        br_req,
  input  logic [31:0] br_tgt,
  input  logic        exc_req,
  output logic        jmp_ack,
  output logic        br_ack,
  output logic        exc_ack,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_fd,
  output logic        flush_dx,
  output logic        stall_f
`ifdef JMP_LINK_EN
  ,
  output logic        link_we,
  output logic [31:0] link_data
`endif
);

  // Counter holds cycles remaining after the current one, so load N-1.
  localparam bcnt_t BUB_LOAD = (BUBBLE_CYCLES > 0) ? bcnt_t'(BUBBLE_CYCLES - 1) : bcnt_t'(0);

  state_t      state, state_nxt;
  src_t        win, src_q;
  logic [31:0] tgt_q, win_tgt;
  logic        cnt_zero;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Only an exception may interrupt a redirect in flight; the others are being flushed.
  always_comb begin
    state_nxt = state;
    win       = SRC_NONE;
    case (state)
      IDLE: begin
        if      (exc_req) win = SRC_EXC;
        else if (br_req)  win = SRC_BR;
        else if (jmp_req) win = SRC_JMP;
      end
      REDIRECT, BUBBLE: begin
        if (exc_req) win = SRC_EXC;
      end
      default: ;
    endcase
    if (!resetn) win = SRC_NONE;

    if (win != SRC_NONE) begin
      state_nxt = REDIRECT;
    end else begin
      case (state)
        REDIRECT: state_nxt = (BUBBLE_CYCLES > 0) ? BUBBLE : IDLE;
        BUBBLE:   if (cnt_zero) state_nxt = IDLE;
        default:  ;
      endcase
    end
  end

  always_comb begin
    jmp_ack        = (win == SRC_JMP);
    br_ack         = (win == SRC_BR);
    exc_ack        = (win == SRC_EXC);
    redirect_valid = (state == REDIRECT);
    flush_fd       = (state == REDIRECT);
    flush_dx       = (state == REDIRECT) && ((src_q == SRC_BR) || (src_q == SRC_EXC));
    stall_f        = (state == BUBBLE);
`ifdef JMP_LINK_EN
    link_we        = (state == REDIRECT) && (src_q == SRC_JMP);
`endif
  end

  always_comb begin
    win_tgt = tgt_q;
    case (win)
      SRC_EXC: win_tgt = EXC_VECTOR;
      SRC_BR:  win_tgt = br_tgt;
      SRC_JMP: win_tgt = sext_jmp(jmp_tgt);
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      src_q <= SRC_NONE;
      tgt_q <= '0;
    end else if (win != SRC_NONE) begin
      src_q <= win;
      tgt_q <= win_tgt;
    end
  end

  assign redirect_pc = tgt_q;

`ifdef JMP_LINK_EN
  logic [31:0] link_data_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)              link_data_q <= '0;
    else if (win == SRC_JMP)  link_data_q <= jmp_pc + 32'd1;
  end

  assign link_data = link_data_q;
`else
  logic unused_jmp_pc;
  assign unused_jmp_pc = ^jmp_pc;
`endif

  redirect_bubble_cnt u_bubble_cnt (
    .clock    (clock),
    .resetn   (resetn),
    .clr      (win != SRC_NONE),
    .load     ((state == REDIRECT) && (state_nxt == BUBBLE)),
    .load_val (BUB_LOAD),
    .dec      (state == BUBBLE),
    .zero     (cnt_zero)
  );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl against a timeline model of redirect and bubble windows.
module tb_pc_redirect_ctrl;

  localparam int N = 3;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        jmp_req = 1'b0, br_req = 1'b0, exc_req = 1'b0;
  logic [26:0] jmp_tgt = '0;
  logic [31:0] jmp_pc = '0, br_tgt = '0;
  logic        jmp_ack, br_ack, exc_ack, redirect_valid, flush_fd, flush_dx, stall_f;
  logic [31:0] redirect_pc;
`ifdef JMP_LINK_EN
  logic        link_we;
  logic [31:0] link_data;
`endif

  pc_redirect_ctrl #(.BUBBLE_CYCLES(N), .EXC_VECTOR(32'h0000_0010)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .jmp_req        (jmp_req),
    .jmp_tgt        (jmp_tgt),
    .jmp_pc         (jmp_pc),
    .br_req         (br_req),
    .br_tgt         (br_tgt),
    .exc_req        (exc_req),
    .jmp_ack        (jmp_ack),
    .br_ack         (br_ack),
    .exc_ack        (exc_ack),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_fd       (flush_fd),
    .flush_dx       (flush_dx),
    .stall_f        (stall_f)
`ifdef JMP_LINK_EN
    ,
    .link_we        (link_we),
    .link_data      (link_data)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [31:0] pc;
    logic        dx;
    logic        lwe;
    logic [31:0] ld;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Model: an accepted request at cycle c owns cycle c+1 (redirect) and c+2..c+1+N (bubble).
  int busy_until = -1;
  int redir_cyc  = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic cycle(input logic jr, input logic [26:0] jt, input logic [31:0] jp,
                       input logic b, input logic [31:0] bt, input logic e);
    int   winner;
    bit   idle;
    int   v;
    exp_t x;
    @(posedge clock); #1;
    jmp_req = jr; jmp_tgt = jt; jmp_pc = jp;
    br_req = b; br_tgt = bt; exc_req = e;
    idle   = (cyc > busy_until);
    winner = 0;
    if (e)               winner = 3;
    else if (idle && b)  winner = 2;
    else if (idle && jr) winner = 1;
    @(negedge clock);
    chk("acks", {29'd0, exc_ack, br_ack, jmp_ack},
        {29'd0, winner == 3, winner == 2, winner == 1});
    chk("stall_f", 32'(stall_f), 32'(!idle && (cyc > redir_cyc)));
    if (winner != 0) begin
      x.c   = cyc;
      x.dx  = (winner >= 2);
      x.lwe = (winner == 1);
      x.ld  = jp + 32'd1;
      if (winner == 3)      x.pc = 32'h10;
      else if (winner == 2) x.pc = bt;
      else begin
        v = int'(jt);
        if (v >= (1 << 26)) v = v - (1 << 27);
        x.pc = 32'(v);
      end
      q.push_back(x);
      redir_cyc  = cyc + 1;
      busy_until = cyc + 1 + N;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clock);
      if (resetn) begin
        if (q.size() > 0 && q[0].c + 1 < cyc) begin
          checks++; errors++;
          $display("FAIL missing_redirect: expected pc %h at cycle %0d", q[0].pc, q[0].c + 1);
          void'(q.pop_front());
        end
        if (redirect_valid) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_redirect: pc %h at cycle %0d, expected none", redirect_pc, cyc);
          end else begin
            x = q.pop_front();
            chk("redirect_cycle", 32'(cyc), 32'(x.c + 1));
            chk("redirect_pc", redirect_pc, x.pc);
            chk("flush_fd", 32'(flush_fd), 32'd1);
            chk("flush_dx", 32'(flush_dx), 32'(x.dx));
`ifdef JMP_LINK_EN
            chk("link_we", 32'(link_we), 32'(x.lwe));
            if (x.lwe) chk("link_data", link_data, x.ld);
`endif
          end
        end else begin
          chk("flush_idle", {30'd0, flush_fd, flush_dx}, 32'd0);
        end
      end
    end
  end

  initial begin : stim
    int s;
    repeat (2) @(negedge clock);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_flags", {27'd0, flush_fd, flush_dx, stall_f, br_ack, exc_ack}, 32'd0);
    resetn = 1'b1;

    // Jump with the most negative immediate, presented in the first cycle out of reset
    cycle(1'b1, 27'h4000000, 32'h20, 1'b0, '0, 1'b0);
    chk("jmp_ack", 32'(jmp_ack), 32'd1);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
    chk("jmp_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("jmp_redirect_pc", redirect_pc, 32'hFC00_0000);
    chk("jmp_flush", {30'd0, flush_fd, flush_dx}, 32'd2);
`ifdef JMP_LINK_EN
    chk("jmp_link_we", 32'(link_we), 32'd1);
    chk("jmp_link_data", link_data, 32'h21);
`endif
    idle_cycles(N + 1);

    // Branch beats jump in the same cycle; then measure the bubble
    cycle(1'b1, 27'h5, 32'h40, 1'b1, 32'h100, 1'b0);
    chk("br_wins_ack", {30'd0, br_ack, jmp_ack}, 32'd2);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
    chk("br_redirect_pc", redirect_pc, 32'h100);
    chk("br_flush_dx", 32'(flush_dx), 32'd1);
    s = 0;
    repeat (N + 2) begin
      cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
      if (stall_f) s++;
    end
    chk("bubble_len", 32'(s), 32'(N));
    cycle(1'b1, 27'h8, 32'h0, 1'b0, '0, 1'b0);
    chk("idle_after_bubble", 32'(jmp_ack), 32'd1);
    idle_cycles(N + 1);

    // Exception pre-empts an in-progress bubble and restarts it
    cycle(1'b0, '0, '0, 1'b1, 32'h200, 1'b0);
    idle_cycles(2);
    cycle(1'b1, 27'h3, '0, 1'b1, 32'h300, 1'b1);
    chk("exc_in_bubble_ack", {29'd0, exc_ack, br_ack, jmp_ack}, 32'd4);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
    chk("exc_redirect_pc", redirect_pc, 32'h10);
    s = 0;
    repeat (N + 2) begin
      cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
      if (stall_f) s++;
    end
    chk("exc_bubble_len", 32'(s), 32'(N));

    // Asynchronous reset while in REDIRECT
    cycle(1'b1, 27'h40, 32'h80, 1'b0, '0, 1'b0);
    @(posedge clock); #1;
    chk("pre_reset_redirect", 32'(redirect_valid), 32'd1);
    jmp_req = 1'b1; exc_req = 1'b1; br_req = 1'b1;
    resetn = 1'b0;
    #1;
    chk("async_rst_flags", {25'd0, redirect_valid, flush_fd, flush_dx, stall_f,
                            jmp_ack, br_ack, exc_ack}, 32'd0);
    chk("async_rst_pc", redirect_pc, 32'd0);
`ifdef JMP_LINK_EN
    chk("async_rst_link", {31'd0, link_we} | link_data, 32'd0);
`endif
    q.delete();
    busy_until = -1;
    redir_cyc  = -1;
    jmp_req = 1'b0; exc_req = 1'b0; br_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    cycle(1'b0, '0, '0, 1'b1, 32'h44, 1'b0);
    chk("post_reset_br_ack", 32'(br_ack), 32'd1);
    idle_cycles(N + 2);

    // Randomized traffic
    repeat (400) begin
      cycle($urandom_range(0, 9) < 3, 27'($urandom), $urandom,
            $urandom_range(0, 9) < 2, $urandom, $urandom_range(0, 19) == 0);
    end
    idle_cycles(N + 3);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
